// File: rtl/undiffer.sv
// undiffer -- comb-filter integrator that rebuilds x[n] from d[n] = x[n] - x[n-DER_SIZE].
//
// It keeps the last DER_SIZE reconstructed samples in a circular history and
// computes x[n] = d[n] + x[n-DER_SIZE] (mod 256). Until DER_SIZE samples have been
// accepted, the history is treated as zero. This matches a zero-initialised
// differencer upstream.
//
// Ports
//   clk                  : single clock, rising edge
//   rst                  : asynchronous, active-high reset
//   clr                  : synchronous flush of pointer, fill count and pending output
//   s_axis_diff_tdata    : difference sample d[n]
//   s_axis_diff_tvalid   : input sample valid
//   s_axis_diff_tready   : input sample accepted when high together with tvalid
//   m_axis_signal_tdata  : reconstructed sample x[n], registered
//   m_axis_signal_tvalid : output sample valid
//   m_axis_signal_tready : downstream ready
//   primed               : high once DER_SIZE samples have been accepted
//
// Handshake: a transfer happens on a rising edge where valid and ready are both
// high. Once valid is raised, the payload stays stable until that transfer. Input
// ready is a pure function of the output register state and downstream ready, so a
// new sample can enter in the same cycle the previous one leaves. There is no skid
// buffer.

module undiffer #(
  parameter int DER_SIZE = 128
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       clr,
  input  logic [7:0] s_axis_diff_tdata,
  input  logic       s_axis_diff_tvalid,
  output logic       s_axis_diff_tready,
  output logic [7:0] m_axis_signal_tdata,
  output logic       m_axis_signal_tvalid,
  input  logic       m_axis_signal_tready,
  output logic       primed
);

  localparam int PW = (DER_SIZE > 1) ? $clog2(DER_SIZE) : 1;
  localparam int FW = $clog2(DER_SIZE + 1);
  localparam logic [PW-1:0] LAST = PW'(DER_SIZE - 1);
  localparam logic [FW-1:0] FULL = FW'(DER_SIZE);

  // History needs no reset: while fill < DER_SIZE its contents are masked to zero.
  logic [7:0]    hist [DER_SIZE];
  logic [PW-1:0] wptr;
  logic [FW-1:0] fill;

  logic          accept;
  logic          full;
  logic [7:0]    h;
  logic [7:0]    y;
  logic [PW-1:0] wptr_next;
  logic [FW-1:0] fill_next;

  assign s_axis_diff_tready = !m_axis_signal_tvalid || m_axis_signal_tready;

  always_comb begin
    accept    = s_axis_diff_tvalid && s_axis_diff_tready;
    full      = (fill == FULL);
    h         = full ? hist[wptr] : 8'h00;
    // Carry is discarded on purpose: the differencer also works mod 256.
    y         = s_axis_diff_tdata + h;
    wptr_next = (wptr == LAST) ? '0 : wptr + 1'b1;
    fill_next = full ? fill : fill + 1'b1;
  end

  // The slot just read as x[n-DER_SIZE] is overwritten with x[n].
  always_ff @(posedge clk) begin
    if (accept && !clr && !rst) begin
      hist[wptr] <= y;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      m_axis_signal_tvalid <= 1'b0;
      m_axis_signal_tdata  <= 8'h00;
      primed               <= 1'b0;
      wptr                 <= '0;
      fill                 <= '0;
    end else if (clr) begin
      // A sample offered in the same cycle is dropped. The output data register
      // keeps its old value because valid is low.
      m_axis_signal_tvalid <= 1'b0;
      primed               <= 1'b0;
      wptr                 <= '0;
      fill                 <= '0;
    end else if (accept) begin
      m_axis_signal_tvalid <= 1'b1;
      m_axis_signal_tdata  <= y;
      wptr                 <= wptr_next;
      fill                 <= fill_next;
      primed               <= (fill_next == FULL);
    end else if (m_axis_signal_tready) begin
      m_axis_signal_tvalid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_undiffer.sv
module tb_undiffer;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  // DER_SIZE = 4 instance
  logic       clr4 = 1'b0;
  logic [7:0] s4_tdata = 8'h00;
  logic       s4_tvalid = 1'b0;
  logic       s4_tready;
  logic [7:0] m4_tdata;
  logic       m4_tvalid;
  logic       m4_tready = 1'b1;
  logic       primed4;

  // DER_SIZE = 128 instance
  logic       clr128 = 1'b0;
  logic [7:0] s128_tdata = 8'h00;
  logic       s128_tvalid = 1'b0;
  logic       s128_tready;
  logic [7:0] m128_tdata;
  logic       m128_tvalid;
  logic       m128_tready = 1'b1;
  logic       primed128;

  undiffer #(.DER_SIZE(4)) dut4 (
    .clk                  (clk),
    .rst                  (rst),
    .clr                  (clr4),
    .s_axis_diff_tdata    (s4_tdata),
    .s_axis_diff_tvalid   (s4_tvalid),
    .s_axis_diff_tready   (s4_tready),
    .m_axis_signal_tdata  (m4_tdata),
    .m_axis_signal_tvalid (m4_tvalid),
    .m_axis_signal_tready (m4_tready),
    .primed               (primed4)
  );

  undiffer #(.DER_SIZE(128)) dut128 (
    .clk                  (clk),
    .rst                  (rst),
    .clr                  (clr128),
    .s_axis_diff_tdata    (s128_tdata),
    .s_axis_diff_tvalid   (s128_tvalid),
    .s_axis_diff_tready   (s128_tready),
    .m_axis_signal_tdata  (m128_tdata),
    .m_axis_signal_tvalid (m128_tvalid),
    .m_axis_signal_tready (m128_tready),
    .primed               (primed128)
  );

  int pass_cnt  = 0;
  int total_cnt = 0;

  logic [7:0] exp4_q[$];
  logic [7:0] exp128_q[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
  endtask

  // Scoreboards: a transfer on the coming edge is decided by the values at the negedge.
  always @(negedge clk) begin
    if (!rst && m4_tvalid && m4_tready) begin
      if (exp4_q.size() == 0) check("out4_unexpected", 32'(m4_tdata), 32'h100);
      else check("out4", 32'(m4_tdata), 32'(exp4_q.pop_front()));
    end
    if (!rst && m128_tvalid && m128_tready) begin
      if (exp128_q.size() == 0) check("out128_unexpected", 32'(m128_tdata), 32'h100);
      else check("out128", 32'(m128_tdata), 32'(exp128_q.pop_front()));
    end
  end

  // Drivers start and end at posedge+1.
  task automatic drive4(input logic [7:0] d, input logic [7:0] e, input bit push);
    int budget = 200;
    s4_tdata  = d;
    s4_tvalid = 1'b1;
    @(negedge clk);
    while (!s4_tready && budget > 0) begin
      @(negedge clk);
      budget--;
    end
    if (!s4_tready) check("drive4_timeout", 32'(s4_tready), 32'h1);
    else if (push) exp4_q.push_back(e);
    @(posedge clk);
    #1;
    s4_tvalid = 1'b0;
  endtask

  task automatic drive128(input logic [7:0] d, input logic [7:0] e);
    int budget = 200;
    s128_tdata  = d;
    s128_tvalid = 1'b1;
    @(negedge clk);
    while (!s128_tready && budget > 0) begin
      @(negedge clk);
      budget--;
    end
    if (!s128_tready) check("drive128_timeout", 32'(s128_tready), 32'h1);
    else exp128_q.push_back(e);
    @(posedge clk);
    #1;
    s128_tvalid = 1'b0;
  endtask

  task automatic drain4();
    int budget = 100;
    while (exp4_q.size() != 0 && budget > 0) begin
      @(posedge clk);
      #1;
      budget--;
    end
    check("drain4", 32'(exp4_q.size()), 32'h0);
  endtask

  typedef struct {
    logic [7:0] din;
    logic [7:0] dout;
    logic       primed;
  } vec_t;

  vec_t vecs[6];
  bit   done128 = 1'b0;

  initial begin
    vecs[0] = '{8'd1, 8'd1, 1'b0};
    vecs[1] = '{8'd2, 8'd2, 1'b0};
    vecs[2] = '{8'd3, 8'd3, 1'b0};
    vecs[3] = '{8'd4, 8'd4, 1'b1};
    vecs[4] = '{8'd5, 8'd6, 1'b1};
    vecs[5] = '{8'd6, 8'd8, 1'b1};

    // Reset state
    #12;
    check("rst_tvalid", 32'(m4_tvalid), 32'h0);
    check("rst_tdata", 32'(m4_tdata), 32'h0);
    check("rst_primed", 32'(primed4), 32'h0);
    check("rst_primed128", 32'(primed128), 32'h0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    #1;
    check("post_rst_tready", 32'(s4_tready), 32'h1);
    @(posedge clk);
    #1;

    // Basic sequence with primed rising after the 4th accept
    for (int i = 0; i < 6; i++) begin
      drive4(vecs[i].din, vecs[i].dout, 1'b1);
      check($sformatf("primed_v%0d", i), 32'(primed4), 32'(vecs[i].primed));
    end
    // History is now {6,8,3,4} with wptr = 2.
    drive4(8'hFD, 8'h00, 1'b1);
    drive4(8'hEC, 8'hF0, 1'b1);
    drive4(8'h00, 8'h06, 1'b1);
    drive4(8'h00, 8'h08, 1'b1);
    drive4(8'h00, 8'h00, 1'b1);
    check("wptr_before_wrap", 32'(dut4.wptr), 32'h3);
    // Modular addition: 0xF0 + 0x20 = 0x10 with the carry dropped
    drive4(8'h20, 8'h10, 1'b1);
    check("wptr_after_wrap", 32'(dut4.wptr), 32'h0);
    drain4();

    // clr takes priority over a simultaneous accept
    s4_tdata  = 8'h07;
    s4_tvalid = 1'b1;
    clr4      = 1'b1;
    @(posedge clk);
    #1;
    clr4      = 1'b0;
    s4_tvalid = 1'b0;
    check("clr_primed", 32'(primed4), 32'h0);
    check("clr_tvalid", 32'(m4_tvalid), 32'h0);
    check("clr_fill", 32'(dut4.fill), 32'h0);
    drive4(8'h05, 8'h05, 1'b1);
    @(posedge clk);
    #1;
    drain4();

    // Backpressure: 0x11 is held for 5 cycles and transfers once
    m4_tready = 1'b0;
    drive4(8'h11, 8'h11, 1'b1);
    s4_tdata  = 8'h22;
    s4_tvalid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("hold_tready", 32'(s4_tready), 32'h0);
      check("hold_tdata", 32'(m4_tdata), 32'h11);
      check("hold_tvalid", 32'(m4_tvalid), 32'h1);
      @(posedge clk);
      #1;
    end
    check("hold_fill", 32'(dut4.fill), 32'h2);
    s4_tvalid = 1'b0;
    m4_tready = 1'b1;
    @(posedge clk);
    #1;
    check("release_tvalid", 32'(m4_tvalid), 32'h0);
    check("release_q", 32'(exp4_q.size()), 32'h0);

    // Asynchronous reset mid-stream with a pending output
    m4_tready = 1'b0;
    drive4(8'hAA, 8'h00, 1'b0);
    s4_tdata  = 8'h33;
    s4_tvalid = 1'b1;
    #2;
    rst = 1'b1;
    #1;
    check("arst_tvalid", 32'(m4_tvalid), 32'h0);
    check("arst_tdata", 32'(m4_tdata), 32'h0);
    check("arst_fill", 32'(dut4.fill), 32'h0);
    check("arst_wptr", 32'(dut4.wptr), 32'h0);
    exp4_q.delete();
    @(posedge clk);
    #3;
    rst       = 1'b0;
    s4_tvalid = 1'b0;
    m4_tready = 1'b1;
    #1;
    check("arst_tready", 32'(s4_tready), 32'h1);
    @(posedge clk);
    #1;
    drive4(8'h09, 8'h09, 1'b1);
    check("arst_primed", 32'(primed4), 32'h0);
    drain4();

    // Random stream through a reference differencer with throttling on both sides
    fork
      begin
        logic [7:0] xh [128];
        logic [7:0] x;
        logic [7:0] prev;
        int budget;
        for (int n = 0; n < 2000; n++) begin
          x    = 8'($urandom_range(0, 255));
          prev = (n >= 128) ? xh[n % 128] : 8'h00;
          xh[n % 128] = x;
          repeat ($urandom_range(0, 2)) begin
            @(posedge clk);
            #1;
          end
          drive128(x - prev, x);
        end
        budget = 2000;
        while (exp128_q.size() != 0 && budget > 0) begin
          @(posedge clk);
          #1;
          budget--;
        end
        check("drain128", 32'(exp128_q.size()), 32'h0);
        check("primed128_end", 32'(primed128), 32'h1);
        done128 = 1'b1;
      end
      begin
        while (!done128) begin
          @(posedge clk);
          #1;
          m128_tready = ($urandom_range(0, 3) != 0);
        end
        m128_tready = 1'b1;
      end
    join

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
